// File: rtl/matvec_engine_if.sv
// Handshake and bus bundle for matvec_engine: memory writes, start control and the result stream.
// The master drives writes, start and out_ready. The slave (the engine) drives status and results.
interface matvec_engine_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_VECTOR_SIZE = 16,
    parameter int NUM_ROWS        = 4
);
    localparam int AW = (MAX_VECTOR_SIZE > 1) ? $clog2(MAX_VECTOR_SIZE) : 1;
    localparam int LW = ($clog2(MAX_VECTOR_SIZE + 1) > 0) ? $clog2(MAX_VECTOR_SIZE + 1) : 1;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    logic [DATA_WIDTH-1:0] data_in;
    logic [RW-1:0]         write_row;
    logic [AW-1:0]         write_addr;
    logic                  write_en_w;
    logic                  write_en_x;
    logic                  write_en_bias;
    logic [LW-1:0]         vector_length;
    logic [RW:0]           row_count;
    logic                  bias_en;
    logic                  start_calc;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [RW-1:0]         out_row;
    logic [DATA_WIDTH-1:0] result;
    logic                  calc_done;
    logic                  err_len;

    modport master (
        output data_in, write_row, write_addr, write_en_w, write_en_x, write_en_bias,
               vector_length, row_count, bias_en, start_calc, out_ready,
        input  busy, out_valid, out_row, result, calc_done, err_len
    );
    modport slave (
        input  data_in, write_row, write_addr, write_en_w, write_en_x, write_en_bias,
               vector_length, row_count, bias_en, start_calc, out_ready,
        output busy, out_valid, out_row, result, calc_done, err_len
    );
endinterface

// File: rtl/matvec_engine.sv
// fp32 matrix-vector engine. Each row computes result = bias + sum(W[r][i]*X[i]), accumulating in index order.
// Each element costs 4 cycles (multiply 1 + add 1 + 2 handshake cycles). EMIT holds each row until out_ready.
module matvec_engine #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_VECTOR_SIZE = 16,
    parameter int NUM_ROWS        = 4
) (
    input  logic             clk,
    input  logic             rstn,
    matvec_engine_if.slave   bus
);
    localparam int AW = (MAX_VECTOR_SIZE > 1) ? $clog2(MAX_VECTOR_SIZE) : 1;
    localparam int LW = ($clog2(MAX_VECTOR_SIZE + 1) > 0) ? $clog2(MAX_VECTOR_SIZE + 1) : 1;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {IDLE, LOAD, MULT, ADD, EMIT, DONE} state_t;

    // Round-to-nearest-even and pack. Subnormal results flush to zero.
    function automatic logic [31:0] fpack(input logic sg, input int e_in, input logic [23:0] m,
                                          input logic g, input logic st);
        int          e;
        logic [24:0] mr;
        e  = e_in;
        mr = {1'b0, m} + {24'd0, g & (st | m[0])};
        if (mr[24]) begin
            mr = {1'b0, mr[24:1]};
            e  = e + 1;
        end
        if (e >= 255) return {sg, 8'hFF, 23'd0};
        if (e <= 0)   return {sg, 31'd0};
        return {sg, e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [23:0] m;
        logic        g, st, sg;
        int          e;
        sg = a[31] ^ b[31];
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
            return QNAN;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
            return (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? QNAN : {sg, 8'hFF, 23'd0};
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sg, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
        end else begin
            m = p[46:23]; g = p[22]; st = |p[21:0];
        end
        return fpack(sg, e, m, g, st);
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [53:0] bext;
        logic [26:0] xs, ys;
        logic [27:0] s;
        int          d, e;
        if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0))
            return QNAN;
        if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return QNAN;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
        if (a[30:23] == 8'd0) return b;
        if (b[30:23] == 8'd0) return a;
        if (b[30:0] > a[30:0]) begin x = b; y = a; end
        else begin x = a; y = b; end
        d = int'(x[30:23]) - int'(y[30:23]);
        if (d > 54) d = 54;
        // Three extra low bits carry guard/round/sticky through the alignment shift.
        bext = {1'b1, y[22:0], 3'b000, 27'd0} >> d;
        ys   = bext[53:27] | {26'd0, |bext[26:0]};
        xs   = {1'b1, x[22:0], 3'b000};
        s    = (x[31] == y[31]) ? ({1'b0, xs} + {1'b0, ys}) : ({1'b0, xs} - {1'b0, ys});
        if (s == 28'd0) return 32'd0;
        e = int'(x[30:23]);
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!s[26]) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
        end
        return fpack(x[31], e, s[26:3], s[2], |s[1:0]);
    endfunction

    logic [DATA_WIDTH-1:0] w_mem [NUM_ROWS][MAX_VECTOR_SIZE];
    logic [DATA_WIDTH-1:0] x_mem [MAX_VECTOR_SIZE];
    logic [DATA_WIDTH-1:0] b_mem [NUM_ROWS];

    state_t                state;
    logic [AW-1:0]         idx_q;
    logic [RW-1:0]         row_q;
    logic [LW-1:0]         len_q;
    logic [RW:0]           rows_q;
    logic                  bias_q, pend_q;
    logic [DATA_WIDTH-1:0] partial_q, product_q, result_q;
    logic                  busy_q, out_valid_q, calc_done_q, err_len_q;
    logic [RW-1:0]         out_row_q;

    always_ff @(posedge clk) begin
        if (!busy_q) begin
            if (bus.write_en_w && int'(bus.write_row) < NUM_ROWS && int'(bus.write_addr) < MAX_VECTOR_SIZE)
                w_mem[bus.write_row][bus.write_addr] <= bus.data_in;
            if (bus.write_en_x && int'(bus.write_addr) < MAX_VECTOR_SIZE)
                x_mem[bus.write_addr] <= bus.data_in;
            if (bus.write_en_bias && int'(bus.write_row) < NUM_ROWS)
                b_mem[bus.write_row] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            idx_q       <= '0;
            row_q       <= '0;
            len_q       <= '0;
            rows_q      <= '0;
            bias_q      <= 1'b0;
            pend_q      <= 1'b0;
            partial_q   <= '0;
            product_q   <= '0;
            result_q    <= '0;
            out_row_q   <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            calc_done_q <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            calc_done_q <= 1'b0;
            err_len_q   <= 1'b0;
            case (state)
                IDLE: if (bus.start_calc) begin
                    if (int'(bus.vector_length) <= MAX_VECTOR_SIZE && bus.row_count != '0 &&
                        int'(bus.row_count) <= NUM_ROWS) begin
                        len_q  <= bus.vector_length;
                        rows_q <= bus.row_count;
                        bias_q <= bus.bias_en;
                        row_q  <= '0;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end else begin
                        err_len_q <= 1'b1;
                    end
                end
                LOAD: begin
                    idx_q <= '0;
                    if (len_q == '0) begin
                        result_q    <= bias_q ? b_mem[row_q] : '0;
                        out_row_q   <= row_q;
                        out_valid_q <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        partial_q <= bias_q ? b_mem[row_q] : '0;
                        state     <= MULT;
                    end
                end
                // Issue cycle computes the operation, second cycle is the done handshake.
                MULT: begin
                    pend_q <= !pend_q;
                    if (!pend_q) product_q <= fmul(w_mem[row_q][idx_q], x_mem[idx_q]);
                    else         state     <= ADD;
                end
                ADD: begin
                    pend_q <= !pend_q;
                    if (!pend_q) begin
                        partial_q <= fadd(partial_q, product_q);
                    end else if (int'(idx_q) + 1 == int'(len_q)) begin
                        result_q    <= partial_q;
                        out_row_q   <= row_q;
                        out_valid_q <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        state <= MULT;
                    end
                end
                EMIT: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    if (int'(row_q) + 1 < int'(rows_q)) begin
                        row_q <= row_q + 1'b1;
                        state <= LOAD;
                    end else begin
                        busy_q      <= 1'b0;
                        calc_done_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.result    = result_q;
    assign bus.calc_done = calc_done_q;
    assign bus.err_len   = err_len_q;
endmodule

// File: doc/matvec_engine.md
MATVEC_ENGINE -- requirements
Module: matvec_engine

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand width; only IEEE-754 single precision (32) is supported.
REQ-002 Parameter MAX_VECTOR_SIZE, 16, maximum vector length; any value of 1 or more is legal.
REQ-003 Parameter NUM_ROWS, 4, number of weight rows (output channels); any value of 1 or more is legal.
REQ-004 Derived widths: AW = clog2(MAX_VECTOR_SIZE), LW = clog2(MAX_VECTOR_SIZE+1), RW = clog2(NUM_ROWS), each with a minimum of 1.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 data_in  in  DATA_WIDTH  write data.
REQ-008 write_row  in  RW  weight or bias row select.
REQ-009 write_addr  in  AW  element index.
REQ-010 write_en_w / write_en_x / write_en_bias  in  1 each  write W[write_row][write_addr], X[write_addr], BIAS[write_row].
REQ-011 vector_length  in  LW  elements per row; sampled at start.
REQ-012 row_count  in  RW+1  rows to compute; sampled at start.
REQ-013 bias_en  in  1  1 seeds each accumulation with BIAS[r]; sampled at start.
REQ-014 start_calc  in  1  single-cycle start request.
REQ-015 busy  out  1  high from accepted start until calc_done.
REQ-016 out_valid, out_ready  out, in  1 each  result stream handshake.
REQ-017 out_row  out  RW  row index of result.
REQ-018 result  out  DATA_WIDTH  fp32 value of the row result.
REQ-019 calc_done  out  1  one-cycle pulse after the last row transfers.
REQ-020 err_len  out  1  one-cycle pulse on a rejected start.

Function
REQ-021 Writes are accepted only when busy=0; a write while busy=1 is ignored; simultaneous enables each write their own memory.
REQ-022 FSM states: IDLE, LOAD, MULT, ADD, EMIT, DONE.
REQ-023 IDLE transitions: start_calc with vector_length<=MAX_VECTOR_SIZE and 1<=row_count<=NUM_ROWS -> LOAD; any other start_calc -> pulse err_len and stay IDLE.
REQ-024 start_calc while busy=1 is ignored.
REQ-025 LOAD: partial = BIAS[r] if bias_en else +0.0, index = 0; if vector_length=0 -> EMIT, else -> MULT.
REQ-026 MULT: fp32 multiply of W[r][index] and X[index] via the team's single-precision multiplier start/done handshake; done -> ADD.
REQ-027 ADD: partial = partial + product via the team's single-precision adder handshake; done -> index+1; index=vector_length-1 -> EMIT, else -> MULT.
REQ-028 Accumulation order is strictly index-ascending, with each operation round-to-nearest-even; results are bit-exact to that sequential order.
REQ-029 EMIT: out_valid=1, result=partial, out_row=r.
REQ-030 EMIT holds out_valid, result and out_row stable until out_valid and out_ready are high on the same edge.
REQ-031 Transfer in EMIT: r+1<row_count -> LOAD for the next row, else -> DONE.
REQ-032 DONE: calc_done=1 for one cycle, busy=0, -> IDLE.
REQ-033 Back-pressure never drops or reorders rows; computation stalls in EMIT.
REQ-034 Memories retain contents across calculations; results for the same inputs are identical.
REQ-035 Latency per row: LOAD 1 cycle + vector_length×(multiplier + adder latency + 2) + EMIT of at least 1 cycle.

Reset
REQ-036 rstn=0 asynchronously forces IDLE and clears index, row counter and partial.
REQ-037 During reset busy, out_valid, calc_done and err_len are 0; result, out_row are 0.
REQ-038 Memory contents are undefined after reset; no clearing is required.
REQ-039 Reset mid-operation aborts with no out_valid or calc_done, and a new start after release behaves normally.

Verification
REQ-040 Stimulus: row_count=1, len=2, W0=[1.0,2.0], X=[3.0,4.0], bias_en=0. Required: one result 0x41300000 on out_row 0, then calc_done.
REQ-041 Stimulus: row_count=2, len=3, X=[5,1,2], W0=[2,-4,3], W1=[1,1,1], BIAS=[0.5,-1.0], bias_en=1. Required: row0 0x41480000 (12.5), then row1 0x40E00000 (7.0), in order.
REQ-042 Stimulus: REQ-041 run with out_ready held low for 10 cycles at first out_valid. Required: out_valid, result and out_row held stable; both rows still delivered; calc_done once.
REQ-043 Stimulus: len=0, bias_en=1, BIAS0=3.0, row_count=1. Required: result 0x40400000.
REQ-044 Stimulus: len=MAX_VECTOR_SIZE+1, or row_count=0. Required: err_len one-cycle pulse, busy stays 0, no out_valid.
REQ-045 Stimulus: rstn low during MULT of row 1, then release and rerun REQ-040. Required: outputs zero during reset, no stale out_valid, result 0x41300000.
